// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared types and constants for the seven-segment display blocks.
//   SEG_BLANK      - all segments off (active-low bus)
//   SEG_MAX_DIGITS - largest digit count the scan driver supports
//   seg_t          - segment bus, bit order gfedcba, active-low
package sevseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t        SEG_BLANK      = 7'h7F;
  localparam int unsigned SEG_MAX_DIGITS = 8;

endpackage

// File: rtl/hex2sevseg.sv
// hex2sevseg: combinational hex nibble to seven-segment decoder.
//   hex_i  4-bit value 0..F
//   seg_o  segments gfedcba, active-low (common-anode)
module hex2sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevseg_scan_mux.sv
// sevseg_scan_mux: time-multiplexed scan driver for an N-digit common-anode display.
// Loads go to a shadow register and are copied to the active register only at the
// frame boundary, so a frame never mixes old and new digits.
//   clk, rst_n - clock, asynchronous active-low reset
//   value_i    - packed hex digits, digit 0 in [3:0]
//   dp_i       - decimal point per digit, 1 = lit
//   load_i     - single-cycle capture strobe into the shadow register
//   an_o       - anode select, active-low one-hot (all ones while blanked)
//   seg_o      - segments gfedcba, active-low
//   dp_o       - decimal point, active-low
//   frame_o    - one-cycle pulse as the digit index wraps to 0
// Optional: define SEVSEG_LZB_EN for leading-zero blanking.
module sevseg_scan_mux
  import sevseg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic                  load_i,
  output logic [N_DIGITS-1:0]   an_o,
  output seg_t                  seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(N_DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*N_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                  pending_q, pending_d;
  logic [N_DIGITS-1:0]   an_d;
  seg_t                  seg_d, dec_seg;
  logic                  dp_d, frame_d;
  logic                  cnt_wrap, boundary, lz_blank;
  logic [3:0]            nibble;

  // Outputs are registered from next-state values so they line up with cnt_q/idx_q.
  hex2sevseg u_dec (
    .hex_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_wrap = (cnt_q == CntMax);
    boundary = cnt_wrap && (idx_q == IdxMax);

    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    pending_d = pending_q;
    if (boundary) begin
      pending_d = 1'b0;
    end
    // A load on the boundary cycle sets pending again for the next frame.
    if (load_i) begin
      sh_val_d  = value_i;
      sh_dp_d   = dp_i;
      pending_d = 1'b1;
    end

    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (boundary && pending_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
    end

    nibble = act_val_d[{idx_d, 2'b00} +: 4];

`ifdef SEVSEG_LZB_EN
    // Blank digits above the most significant nonzero nibble; digit 0 never blanks.
    begin
      logic [IdxW-1:0] msnz;
      msnz = '0;
      for (int i = 1; i < int'(N_DIGITS); i++) begin
        if (act_val_d[4*i +: 4] != 4'h0) begin
          msnz = IdxW'(i);
        end
      end
      lz_blank = (idx_d > msnz);
    end
`else
    lz_blank = 1'b0;
`endif

    seg_d   = lz_blank ? SEG_BLANK : dec_seg;
    dp_d    = ~act_dp_d[idx_d];
    an_d    = (cnt_d < BlankCnt) ? '1 : ~(N_DIGITS'(1) << idx_d);
    frame_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      pending_q <= 1'b0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      an_o      <= '1;
      seg_o     <= SEG_BLANK;
      dp_o      <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      pending_q <= pending_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      an_o      <= an_d;
      seg_o     <= seg_d;
      dp_o      <= dp_d;
      frame_o   <= frame_d;
    end
  end

endmodule
